// File: rtl/mux_16x1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_16x1_rr_sched
//
// Round-robin scheduler that owns the sel input of a mux_16x1. Sixteen
// level-sensitive requesters compete for the mux. The winner gets a one-hot
// grant for a bounded tenure of at most MAX_HOLD consecutive cycles. A new
// grant is handed over on the same edge that releases the old one, so there is
// no idle cycle between grants.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles a single grant may last (1..256)
//   CNT_W     tenure counter width, derived from MAX_HOLD (do not override)
//
// Ports:
//   clk_i     clock, rising-edge active
//   rst_ni    asynchronous active-low reset
//   req_i     request vector, bit k = requester k, level-sensitive
//   lock_i    tenure lock, present only when MUX_SCHED_LOCK_EN is defined
//   gnt_o     registered one-hot grant, all-zero when idle
//   sel_o     registered index of the current or last grantee (mux sel)
//   valid_o   high while gnt_o is nonzero; qualifies mux_16x1.out_o
//   tenure_o  cycles already spent by the current grantee, starts at 0
//
// Build option:
//   MUX_SCHED_LOCK_EN  adds lock_i. While lock_i=1 and the holder still
//                      requests, expiry is suppressed and tenure_o saturates
//                      at MAX_HOLD-1.
//
// Handshake: a requester raises req_i[k] and keeps it high for as long as it
// wants the mux; it owns the mux exactly in the cycles where gnt_o[k]=1 (and
// valid_o=1). There is no back-pressure: dropping req_i[k] is the release.
// valid_o is the FSM state itself (1 = GRANT, 0 = IDLE), so it doubles as the
// state observation point.
// -----------------------------------------------------------------------------
module mux_16x1_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      req_i,
`ifdef MUX_SCHED_LOCK_EN
    input  logic             lock_i,
`endif
    output logic [15:0]      gnt_o,
    output logic [3:0]       sel_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] tenure_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] TEN_MAX = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       sel_q, sel_d;
    logic [15:0]      gnt_q, gnt_d;
    logic [CNT_W-1:0] ten_q, ten_d;

    logic             hold_req;
    logic             at_max;
    logic             locked;
    logic             expire;
    logic             do_release;
    logic [15:0]      cand;
    logic             win_found;
    logic [3:0]       win_idx;
    logic [3:0]       scan_idx;

    // Release evaluation for the current holder (sel_q while in GRANT).
    always_comb begin
        hold_req = req_i[sel_q];
        at_max   = (ten_q == TEN_MAX);
`ifdef MUX_SCHED_LOCK_EN
        locked   = lock_i & hold_req;
`else
        locked   = 1'b0;
`endif
        expire     = at_max & ~locked;
        do_release = ~hold_req | expire;
    end

    // Candidate vector: on a voluntary release the holder is masked out; on
    // expiry it stays in, but ranks last because ptr already points past it.
    always_comb begin
        cand = req_i;
        if (state_q == ST_GRANT && !hold_req) begin
            cand = req_i & ~(16'h0001 << sel_q);
        end
    end

    // Rotating search starting at ptr, wrapping 15 -> 0; first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int i = 0; i < 16; i++) begin
            scan_idx = ptr_q + 4'(i);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ten_d   = ten_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 16'h0001 << win_idx;
                    sel_d   = win_idx;
                    ptr_d   = win_idx + 4'd1;
                    ten_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!do_release) begin
                    // Saturate only matters when lock suppresses expiry.
                    if (!at_max) begin
                        ten_d = ten_q + CNT_W'(1);
                    end
                end else if (win_found) begin
                    gnt_d = 16'h0001 << win_idx;
                    sel_d = win_idx;
                    ptr_d = win_idx + 4'd1;
                    ten_d = '0;
                end else begin
                    // sel_q is kept so the mux output stays stable while idle.
                    state_d = ST_IDLE;
                    gnt_d   = 16'h0000;
                    ten_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            sel_q   <= 4'd0;
            gnt_q   <= 16'h0000;
            ten_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ten_q   <= ten_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign sel_o    = sel_q;
    assign valid_o  = (state_q == ST_GRANT);
    assign tenure_o = ten_q;

endmodule

// File: tb/tb_mux_16x1_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_16x1_rr_sched
//
// Self-checking bench for mux_16x1_rr_sched. A behavioural model (integer
// holder / tenure / pointer, rotation via modulo arithmetic) predicts the
// outputs after every clock edge; predictions go through an expected queue
// and are compared against the DUT. Directed scenarios add fixed expected
// sequences; a randomized phase covers the rest.
// -----------------------------------------------------------------------------
module tb_mux_16x1_rr_sched;

    localparam int MH = 4;
    localparam int CW = $clog2(MH + 1);
`ifdef MUX_SCHED_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk_i;
    logic          rst_ni;
    logic [15:0]   req_i;
    logic          lock_i;
    logic [15:0]   gnt_o;
    logic [3:0]    sel_o;
    logic          valid_o;
    logic [CW-1:0] tenure_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mux_16x1_rr_sched #(.MAX_HOLD(MH)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
`ifdef MUX_SCHED_LOCK_EN
        .lock_i   (lock_i),
`endif
        .gnt_o    (gnt_o),
        .sel_o    (sel_o),
        .valid_o  (valid_o),
        .tenure_o (tenure_o)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_holder;   // -1 when idle
    int m_ten;
    int m_ptr;
    int m_sel;

    function automatic int rr_pick(input logic [15:0] c, input int p);
        for (int k = 0; k < 16; k++) begin
            if (c[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ten    = 0;
        m_ptr    = 0;
        m_sel    = 0;
    endtask

    task automatic model_grant(input int w);
        m_holder = w;
        m_sel    = w;
        m_ten    = 0;
        m_ptr    = (w + 1) % 16;
    endtask

    task automatic model_step(input logic [15:0] r, input logic l);
        logic [15:0] c;
        int w;
        bit vol, exp_hit;
        if (m_holder < 0) begin
            w = rr_pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            vol     = (r[m_holder] == 1'b0);
            exp_hit = (m_ten == MH - 1) && !(LOCK_EN && l && r[m_holder]);
            if (vol || exp_hit) begin
                c = r;
                if (vol) c[m_holder] = 1'b0;
                w = rr_pick(c, m_ptr);
                if (w >= 0) model_grant(w);
                else begin
                    m_holder = -1;
                    m_ten    = 0;
                end
            end else if (m_ten < MH - 1) begin
                m_ten = m_ten + 1;
            end
        end
        exp_q.push_back((m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
        exp_q.push_back(32'(m_sel));
        exp_q.push_back((m_holder >= 0) ? 32'd1 : 32'd0);
        exp_q.push_back(32'(m_ten));
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] e_gnt, e_sel, e_val, e_ten;
        e_gnt = exp_q.pop_front();
        e_sel = exp_q.pop_front();
        e_val = exp_q.pop_front();
        e_ten = exp_q.pop_front();
        check_eq($sformatf("%s.gnt", tag),    32'(gnt_o),    e_gnt);
        check_eq($sformatf("%s.sel", tag),    32'(sel_o),    e_sel);
        check_eq($sformatf("%s.valid", tag),  32'(valid_o),  e_val);
        check_eq($sformatf("%s.tenure", tag), 32'(tenure_o), e_ten);
    endtask

    // ---------------- driver tasks ----------------
    // Entry/exit point of every task: 1 time unit after a rising edge.
    task automatic step(input string tag, input logic [15:0] r, input logic l);
        req_i  = r;
        lock_i = l;
        @(posedge clk_i);
        model_step(r, l);
        #1;
        compare_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq($sformatf("%s.gnt", tag),    32'(gnt_o),    32'h0);
        check_eq($sformatf("%s.sel", tag),    32'(sel_o),    32'h0);
        check_eq($sformatf("%s.valid", tag),  32'(valid_o),  32'h0);
        check_eq($sformatf("%s.tenure", tag), 32'(tenure_o), 32'h0);
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        req_i  = 16'h0;
        lock_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] r;
        logic        l;
        int          sel_tab[12];
        int          ten_tab[10];

        rst_ni = 1'b0;
        req_i  = 16'h0;
        lock_i = 1'b0;
        #2;
        reset_dut();

        // Contention: 0 x4, 15 x4, 0 x4 with no idle cycle.
        sel_tab = '{0, 0, 0, 0, 15, 15, 15, 15, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step("contend", 16'h8001, 1'b0);
            check_eq("contend.sel_seq", 32'(sel_o), 32'(sel_tab[i]));
            check_eq("contend.valid_seq", 32'(valid_o), 32'h1);
        end

        // Voluntary release: two granted cycles, then idle with sel kept at 4.
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            step("vol", 16'h0010, 1'b0);
            check_eq("vol.gnt_fix", 32'(gnt_o), 32'h0010);
        end
        for (int i = 0; i < 2; i++) begin
            step("vol_idle", 16'h0000, 1'b0);
            check_eq("vol_idle.valid_fix", 32'(valid_o), 32'h0);
            check_eq("vol_idle.sel_fix", 32'(sel_o), 32'h4);
        end

        // Sole requester: grant constant, tenure 0,1,2,3,0,...
        reset_dut();
        ten_tab = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 10; i++) begin
            step("sole", 16'h0040, 1'b0);
            check_eq("sole.gnt_fix", 32'(gnt_o), 32'h0040);
            check_eq("sole.ten_seq", 32'(tenure_o), 32'(ten_tab[i]));
        end

        // Wrap: 15 expires, then 1 wins before 15 again.
        reset_dut();
        step("wrap", 16'h8000, 1'b0);
        step("wrap", 16'h8000, 1'b0);
        step("wrap", 16'h8002, 1'b0);
        step("wrap", 16'h8002, 1'b0);
        check_eq("wrap.before", 32'(sel_o), 32'd15);
        step("wrap", 16'h8002, 1'b0);
        check_eq("wrap.after", 32'(sel_o), 32'd1);

        // Asynchronous reset in the middle of a grant.
        for (int i = 0; i < 3; i++) step("pre_rst", 16'hFFFF, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk_i);
        #1;
        model_reset();
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step("post_rst", 16'hFFFF, 1'b0);
            check_eq("post_rst.rotate", 32'(sel_o), 32'(i / MH));
        end

`ifdef MUX_SCHED_LOCK_EN
        // Lock: holder 0 keeps the grant with tenure stuck at MH-1.
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            step("lock", 16'h0003, 1'b1);
            check_eq("lock.sel_fix", 32'(sel_o), 32'h0);
        end
        check_eq("lock.ten_sat", 32'(tenure_o), 32'(MH - 1));
        step("unlock", 16'h0003, 1'b0);
        check_eq("unlock.sel", 32'(sel_o), 32'h1);
`endif

        // Randomized phase.
        reset_dut();
        r = 16'h0;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       r = 16'h0;
                1:       r = 16'($urandom);
                2:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                3:       r = 16'h0001 << $urandom_range(0, 15);
                default: ; // hold previous pattern
            endcase
            l = LOCK_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
            step("rand", r, l);
        end

        check_eq("exp_q.empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_16x1_rr_sched.md
# mux_16x1_rr_sched

Round-robin scheduler that shares the `mux_16x1` datapath between 16 requesters. Each cycle it decides which requester owns the mux. It drives the mux `sel` input from `sel_o`, and gives each requester a one-hot grant. Each grant lasts a bounded tenure. The block sits directly in front of `mux_16x1` and replaces the static `sel` drive.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester may hold the grant. Legal range 1..256.
- `CNT_W`, default `$clog2(MAX_HOLD+1)`: width of the tenure counter. Derived; do not override.

Ports:
- `clk_i`, input, 1: single clock. All state updates on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `req_i`, input, 16: request vector. Bit k is requester k, level-sensitive.
- `gnt_o`, output, 16: one-hot grant, all-zero when idle. Registered.
- `sel_o`, output, 4: index of the current or last grantee. Connects to `mux_16x1.sel`. Registered.
- `valid_o`, output, 1: high while `gnt_o` is nonzero. Qualifies `mux_16x1.out_o`.
- `tenure_o`, output, `CNT_W`: cycles already spent by the current grantee, starting at 0.
- `lock_i`, input, 1: present only with `MUX_SCHED_LOCK_EN`.

## Operation
- FSM has two states, IDLE and GRANT. The reset state is IDLE.
- **Round-robin pointer `ptr` (4 bits):**
  - The search starts at `ptr` and proceeds upward, wrapping from 15 to 0. The first set bit of the candidate vector wins.
  - On every new grant, `ptr` becomes winner+1 mod 16, so 15 wraps to 0.
- **IDLE:**
  - If `req_i` is zero, stay in IDLE.
  - Otherwise go to GRANT. Set `gnt_o` one-hot to the winner, `sel_o` to the winner index, `valid_o` to 1, and `tenure_o` to 0.
- **GRANT:** the current holder is h. Each cycle evaluates the release condition:
  - Release when `req_i[h]` is 0 (voluntary release), or
  - Release when `tenure_o == MAX_HOLD-1` (expiry).
- **No release:** `tenure_o` increments by 1. `gnt_o` and `sel_o` hold.
- **On release:** re-arbitrate in the same edge over the candidate vector.
  - Candidate vector is `req_i` with bit h masked on voluntary release. On expiry it is `req_i` unmasked.
  - Because `ptr` = h+1, h ranks last among candidates.
  - If a winner exists: stay in GRANT with the new winner, no idle bubble, and `tenure_o` reset to 0.
  - If no winner: go to IDLE. `gnt_o`=0, `valid_o`=0, `tenure_o`=0.
- **Sole requester on expiry:** h re-wins. `gnt_o` stays constant and `tenure_o` restarts at 0.
- **`sel_o` while idle:** holds the last granted index so the mux output stays stable. It is not cleared.
- **`MAX_HOLD`=1:** every grant lasts exactly one cycle. Requesters rotate each cycle while several request.
- **Simultaneous requests:** only the rotation order decides the winner. There is no fixed priority.
- **Requests and tenure:** a request dropped then re-raised by a non-holder has no effect on the current tenure.

## Timing
- Grant latency is 1 cycle: if `req_i[k]` is set before edge n, `gnt_o[k]` is visible after edge n when the block is idle.
- Handover latency is 0 idle cycles. Release and the new grant occur on the same edge.
- Release latency:
  - A holder dropping `req_i[h]` before edge n loses its grant after edge n.
  - A holder never keeps the grant for more than `MAX_HOLD` consecutive cycles unless re-won.
- Outputs after reset: `gnt_o`=16'h0000, `sel_o`=4'h0, `valid_o`=0, `tenure_o`=0, and `ptr`=0.
- Reset asserted mid-grant clears everything asynchronously, with no wait for a clock edge.
- After reset release, the first arbitration starts from requester 0.
- No combinational path from `req_i` to any output.

## Configuration
- **`MUX_SCHED_LOCK_EN` defined:**
  - Adds input `lock_i`.
  - While `lock_i`=1 and `req_i[h]`=1, expiry is suppressed and `tenure_o` saturates at `MAX_HOLD-1`.
  - Voluntary release still applies.
  - When `lock_i` falls with `tenure_o` saturated, the next edge expires the grant.
- **`MUX_SCHED_LOCK_EN` undefined:** the port is absent and expiry always applies.

## Test plan
- **Reset:** apply `rst_ni`=0 mid-grant with `req_i`=16'hFFFF. Required: outputs go to 0 immediately. After release, `sel_o` grants 0, 1, 2, … rotating.
- **Contention:** `req_i`=16'h8001 held, `MAX_HOLD`=4. Required: grant 0 for 4 cycles, then 15 for 4 cycles, then 0, with no idle cycle between grants.
- **Voluntary release:** `req_i`=16'h0010 for 2 cycles, then 16'h0000. Required: `gnt_o`=16'h0010, `sel_o`=4, `valid_o`=1 for 2 cycles, then `valid_o`=0 and `sel_o` stays 4.
- **Sole requester:** `req_i`=16'h0040 held for 10 cycles. Required: `gnt_o` constant at 16'h0040 and `tenure_o` sequence 0,1,2,3,0,1,2,3,0,1.
- **Wrap:** `req_i`=16'h8000 then 16'h8002. Required: after 15 is released on expiry, 1 wins before 15 again.
- **Lock:** with `MUX_SCHED_LOCK_EN`, `lock_i`=1, `req_i`=16'h0003, holder 0. Required: holder 0 keeps the grant for 10 cycles with `tenure_o` stuck at 3. After `lock_i` falls, requester 1 is granted on the next edge.
